bp_cce_inv_seq: RTL and testbench
=================================

BP_CCE_INV_SEQ -- requirements
Module: bp_cce_inv_seq

Interface
REQ-001 Parameter num_lce_p, default 8, number of LCEs (>=2).
REQ-002 Parameter lce_assoc_width_p, default 3, LCE way index width.
REQ-003 Parameter lce_id_width_p, default 3, LCE ID width (>= clog2(num_lce_p)).
REQ-004 clk_i  in  1  single clock, all state on posedge.
REQ-005 reset_i  in  1  synchronous, active-low reset (0 = reset).
REQ-006 start_v_i  in  1  request to begin an invalidation sequence.
REQ-007 start_ready_o  out  1  high only in IDLE; start accepted on start_v_i & start_ready_o.
REQ-008 sharers_hits_i  in  num_lce_p  per-LCE directory hit vector, sampled at start.
REQ-009 sharers_ways_i  in  num_lce_p x lce_assoc_width_p  per-LCE hit way, sampled at start.
REQ-010 req_lce_i  in  lce_id_width_p  requesting LCE ID, sampled at start.
REQ-011 exclude_req_i  in  1  when high at start, requesting LCE is removed from target set.
REQ-012 inv_v_o  out  1  invalidate command valid.
REQ-013 inv_ready_i  in  1  downstream accepts command when inv_v_o & inv_ready_i.
REQ-014 inv_lce_o  out  lce_id_width_p  target LCE ID, zero-extended.
REQ-015 inv_way_o  out  lce_assoc_width_p  target way.
REQ-016 ack_v_i  in  1  one invalidate-ack received this cycle.
REQ-017 busy_o  out  1  high in any state other than IDLE.
REQ-018 done_v_o  out  1  one-cycle pulse: all commands sent and all acks received.
REQ-019 inv_count_o  out  clog2(num_lce_p+1)  commands issued in current/last sequence.
REQ-020 err_o  out  1  sticky protocol error flag.

Function
REQ-021 States IDLE, SEND, WAIT, DONE; one-hot or binary encoding is implementer's choice.
REQ-022 On accepted start: target mask = sharers_hits_i & ~(exclude_req_i ? onehot(req_lce_i low bits) : 0); ways, mask latched; inv_count_o and pending counter cleared.
REQ-023 IDLE -> SEND if latched mask nonzero; IDLE -> DONE if mask zero.
REQ-024 SEND: inv_v_o=1 with lowest-index set mask bit as inv_lce_o and its latched way as inv_way_o.
REQ-025 Command fields shall stay stable while inv_v_o & ~inv_ready_i.
REQ-026 On handshake: clear that mask bit, inv_count_o+1, pending+1; next target presented the following cycle (one command per cycle max).
REQ-027 SEND -> WAIT on handshake of last target if pending after update is nonzero; -> DONE if it is zero.
REQ-028 ack_v_i in SEND or WAIT decrements pending; simultaneous handshake and ack leaves pending unchanged.
REQ-029 WAIT -> DONE on cycle pending becomes 0 (ack with pending==1).
REQ-030 DONE: done_v_o=1 for exactly one cycle, then -> IDLE; start_ready_o=0 in DONE.
REQ-031 Latency: start at cycle t -> first inv_v_o at t+1; empty mask -> done_v_o at t+1.
REQ-032 ack_v_i when pending==0 (including IDLE/DONE) sets err_o and is otherwise ignored (pending does not underflow).
REQ-033 Pending and inv_count_o width clog2(num_lce_p+1); cannot exceed num_lce_p.
REQ-034 sharers_*/req_lce_i/exclude_req_i changes after start have no effect on current sequence.
REQ-035 inv_count_o holds its final value through IDLE until next accepted start.

Reset
REQ-036 reset_i=0 at a clock edge, including mid-sequence: state IDLE, mask/pending/inv_count_o=0, err_o=0, inv_v_o=0, done_v_o=0, busy_o=0, start_ready_o=1 from the first cycle after reset.
REQ-037 Outstanding commands/acks at reset are discarded; no done_v_o is produced for the aborted sequence.

Verification
REQ-038 hits=8'b1010_0100, exclude=0, inv_ready_i=1, acks 2 cycles after each send -> commands to LCE 2,5,7 on consecutive cycles, done_v_o one cycle after third ack, inv_count_o=3.
REQ-039 hits=8'b0000_0010, req_lce=1, exclude=1 -> no inv_v_o, done_v_o at t+1, inv_count_o=0.
REQ-040 hits=8'hFF, inv_ready_i low 3 cycles on first command -> LCE 0 held stable 3 cycles, then 0..7 sent, done after 8 acks, inv_count_o=8.
REQ-041 Handshake and ack_v_i same cycle repeatedly (hits=8'h0F) -> pending stays 1 during SEND, done after final ack, err_o=0.
REQ-042 ack_v_i in IDLE -> err_o=1 and stays 1; next sequence still completes correctly.
REQ-043 reset_i=0 in WAIT with pending=2 -> IDLE, busy_o=0, err_o=0, no done_v_o, later acks while idle set err_o.

Source files
------------

// File: rtl/bp_cce_inv_seq.sv
// Invalidation sequencer: issues one invalidate per sharer (lowest LCE first), counts acks, pulses done.
// First command one cycle after start; command held stable while inv_ready_i is low, start only taken in idle.
module bp_cce_inv_seq #(
  parameter int num_lce_p         = 8,
  parameter int lce_assoc_width_p = 3,
  parameter int lce_id_width_p    = 3,
  localparam int cnt_width_lp     = $clog2(num_lce_p + 1),
  localparam int lce_sel_width_lp = $clog2(num_lce_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   start_v_i,
  output logic                                   start_ready_o,
  input  logic [num_lce_p-1:0]                   sharers_hits_i,
  input  logic [num_lce_p*lce_assoc_width_p-1:0] sharers_ways_i,
  input  logic [lce_id_width_p-1:0]              req_lce_i,
  input  logic                                   exclude_req_i,
  output logic                                   inv_v_o,
  input  logic                                   inv_ready_i,
  output logic [lce_id_width_p-1:0]              inv_lce_o,
  output logic [lce_assoc_width_p-1:0]           inv_way_o,
  input  logic                                   ack_v_i,
  output logic                                   busy_o,
  output logic                                   done_v_o,
  output logic [cnt_width_lp-1:0]                inv_count_o,
  output logic                                   err_o
);

  typedef enum logic [1:0] {e_idle, e_send, e_wait, e_done} state_e;

  state_e                                 state_r, state_n;
  logic [num_lce_p-1:0]                   mask_r, mask_n, start_mask;
  logic [num_lce_p*lce_assoc_width_p-1:0] ways_r, ways_n;
  logic [cnt_width_lp-1:0]                pend_r, pend_n, cnt_r, cnt_n;
  logic                                   err_r, err_n;
  logic                                   hs, ack_ok;

  // Scan downward so the lowest set bit is the one that sticks.
  always_comb begin
    inv_lce_o = '0;
    inv_way_o = '0;
    for (int i = num_lce_p - 1; i >= 0; i--) begin
      if (mask_r[i]) begin
        inv_lce_o = lce_id_width_p'(i);
        inv_way_o = ways_r[i*lce_assoc_width_p +: lce_assoc_width_p];
      end
    end
  end

  assign start_mask = sharers_hits_i &
                      ~(exclude_req_i ? (num_lce_p'(1) << req_lce_i[lce_sel_width_lp-1:0]) : '0);

  always_comb begin
    state_n       = state_r;
    mask_n        = mask_r;
    ways_n        = ways_r;
    cnt_n         = cnt_r;
    err_n         = err_r;
    start_ready_o = (state_r == e_idle);
    inv_v_o       = (state_r == e_send);
    busy_o        = (state_r != e_idle);
    done_v_o      = (state_r == e_done);

    hs     = inv_v_o & inv_ready_i;
    // An ack with nothing outstanding is flagged and dropped, so pending never wraps.
    ack_ok = ack_v_i & (pend_r != '0) & ((state_r == e_send) | (state_r == e_wait));
    if (ack_v_i & ~ack_ok) err_n = 1'b1;
    pend_n = pend_r + cnt_width_lp'(hs) - cnt_width_lp'(ack_ok);

    unique case (state_r)
      e_idle: begin
        if (start_v_i) begin
          mask_n  = start_mask;
          ways_n  = sharers_ways_i;
          cnt_n   = '0;
          pend_n  = '0;
          state_n = (start_mask != '0) ? e_send : e_done;
        end
      end
      e_send: begin
        if (hs) begin
          mask_n = mask_r & (mask_r - num_lce_p'(1));
          cnt_n  = cnt_r + cnt_width_lp'(1);
          if (mask_n == '0) state_n = (pend_n != '0) ? e_wait : e_done;
        end
      end
      e_wait: begin
        if (pend_n == '0) state_n = e_done;
      end
      e_done: begin
        state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r <= e_idle;
      mask_r  <= '0;
      ways_r  <= '0;
      pend_r  <= '0;
      cnt_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      mask_r  <= mask_n;
      ways_r  <= ways_n;
      pend_r  <= pend_n;
      cnt_r   <= cnt_n;
      err_r   <= err_n;
    end
  end

  assign inv_count_o = cnt_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_bp_cce_inv_seq.sv
// Bench for bp_cce_inv_seq: directed scenarios plus random traffic against a queue-based model.
module tb_bp_cce_inv_seq;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int IW = 3;
  localparam int CW = $clog2(N + 1);

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            reset_i, start_v_i, start_ready_o;
  logic [N-1:0]    sharers_hits_i;
  logic [N*AW-1:0] sharers_ways_i;
  logic [IW-1:0]   req_lce_i;
  logic            exclude_req_i, inv_v_o, inv_ready_i;
  logic [IW-1:0]   inv_lce_o;
  logic [AW-1:0]   inv_way_o;
  logic            ack_v_i, busy_o, done_v_o, err_o;
  logic [CW-1:0]   inv_count_o;

  bp_cce_inv_seq #(.num_lce_p(N), .lce_assoc_width_p(AW), .lce_id_width_p(IW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_v_i(start_v_i), .start_ready_o(start_ready_o),
    .sharers_hits_i(sharers_hits_i), .sharers_ways_i(sharers_ways_i), .req_lce_i(req_lce_i),
    .exclude_req_i(exclude_req_i), .inv_v_o(inv_v_o), .inv_ready_i(inv_ready_i),
    .inv_lce_o(inv_lce_o), .inv_way_o(inv_way_o), .ack_v_i(ack_v_i), .busy_o(busy_o),
    .done_v_o(done_v_o), .inv_count_o(inv_count_o), .err_o(err_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: outstanding targets in issue order, counters as plain ints.
  int tq_lce[$];
  int tq_way[$];
  int m_pend = 0, m_cnt = 0;
  bit m_active = 0, m_done = 0, m_err = 0;
  int sent_q[$];
  int done_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: check this cycle's outputs, drive inputs, advance the model to the next edge.
  task automatic step(input bit rst_n, input bit st, input logic [N-1:0] hits,
                      input logic [N*AW-1:0] ways, input logic [IW-1:0] req,
                      input bit excl, input bit rdy, input bit ack);
    bit hs;
    @(negedge clk_i);
    chk("start_ready", start_ready_o, !m_active && !m_done);
    chk("busy", busy_o, m_active || m_done);
    chk("done_v", done_v_o, m_done);
    chk("inv_v", inv_v_o, m_active && tq_lce.size() > 0);
    if (m_active && tq_lce.size() > 0) begin
      chk("inv_lce", inv_lce_o, tq_lce[0]);
      chk("inv_way", inv_way_o, tq_way[0]);
    end
    chk("inv_count", inv_count_o, m_cnt);
    chk("err", err_o, m_err);
    if (done_v_o) done_seen++;
    if (inv_v_o && rdy) sent_q.push_back(int'(inv_lce_o));

    reset_i = rst_n; start_v_i = st; sharers_hits_i = hits; sharers_ways_i = ways;
    req_lce_i = req; exclude_req_i = excl; inv_ready_i = rdy; ack_v_i = ack;

    if (!rst_n) begin
      tq_lce.delete(); tq_way.delete();
      m_pend = 0; m_cnt = 0; m_active = 0; m_done = 0; m_err = 0;
    end else if (m_done) begin
      m_done = 0;
      if (ack) m_err = 1;
    end else if (!m_active) begin
      if (ack) m_err = 1;
      if (st) begin
        for (int i = 0; i < N; i++)
          if (hits[i] && !(excl && int'(req) == i)) begin
            tq_lce.push_back(i);
            tq_way.push_back(int'(ways[i*AW +: AW]));
          end
        m_cnt = 0; m_pend = 0;
        if (tq_lce.size() == 0) m_done = 1; else m_active = 1;
      end
    end else begin
      hs = (tq_lce.size() > 0) && rdy;
      if (ack) begin
        if (m_pend > 0) m_pend--; else m_err = 1;
      end
      if (hs) begin
        void'(tq_lce.pop_front()); void'(tq_way.pop_front());
        m_pend++; m_cnt++;
      end
      if (tq_lce.size() == 0 && m_pend == 0) begin
        m_active = 0; m_done = 1;
      end
    end
  endtask

  // Start a sequence, then run n cycles with per-cycle ready/ack masks and scrambled sharer inputs.
  task automatic seq(input logic [N-1:0] hits, input logic [IW-1:0] req, input bit excl,
                     input logic [31:0] rdy_m, input logic [31:0] ack_m, input int n);
    sent_q.delete();
    done_seen = 0;
    step(1, 1, hits, N*AW'($urandom()), req, excl, 1'b1, 1'b0);
    for (int j = 1; j <= n; j++)
      step(1, 0, N'($urandom()), N*AW'($urandom()), IW'($urandom()), 1'($urandom()),
           rdy_m[j], ack_m[j]);
  endtask

  initial begin
    reset_i = 0; start_v_i = 0; sharers_hits_i = '0; sharers_ways_i = '0;
    req_lce_i = '0; exclude_req_i = 0; inv_ready_i = 0; ack_v_i = 0;
    repeat (2) @(posedge clk_i);
    step(0, 0, '0, '0, '0, 0, 0, 0);
    step(1, 0, '0, '0, '0, 0, 0, 0);

    // Three sharers, ack two cycles after each send.
    seq(8'b1010_0100, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h38, 7);
    chk("r38_nsent", sent_q.size(), 3);
    if (sent_q.size() == 3) begin
      chk("r38_lce0", sent_q[0], 2); chk("r38_lce1", sent_q[1], 5); chk("r38_lce2", sent_q[2], 7);
    end
    chk("r38_done", done_seen, 1);
    chk("r38_cnt", inv_count_o, 3);

    // Only sharer is the excluded requester.
    seq(8'b0000_0010, 3'd1, 1'b1, 32'hFFFF_FFFF, 32'h0, 3);
    chk("r39_nsent", sent_q.size(), 0);
    chk("r39_done", done_seen, 1);
    chk("r39_cnt", inv_count_o, 0);

    // All sharers, first command stalled three cycles.
    seq(8'hFF, 3'd0, 1'b0, ~32'hE, 32'h000F_F000, 21);
    chk("r40_nsent", sent_q.size(), 8);
    for (int k = 0; k < 8 && k < sent_q.size(); k++) chk("r40_order", sent_q[k], k);
    chk("r40_done", done_seen, 1);
    chk("r40_cnt", inv_count_o, 8);

    // Handshake and ack in the same cycle.
    seq(8'h0F, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h3C, 7);
    chk("r41_done", done_seen, 1);
    chk("r41_err", err_o, 0);
    chk("r41_cnt", inv_count_o, 4);

    // Spurious ack while idle is sticky; next sequence still completes.
    step(1, 0, '0, '0, '0, 0, 1, 1);
    seq(8'h11, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h18, 6);
    chk("r42_err", err_o, 1);
    chk("r42_done", done_seen, 1);
    chk("r42_cnt", inv_count_o, 2);

    // Reset while waiting on two acks.
    seq(8'h07, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h10, 4);
    done_seen = 0;
    step(0, 0, '0, '0, '0, 0, 1, 0);
    step(1, 0, '0, '0, '0, 0, 1, 0);
    chk("r43_busy", busy_o, 0);
    chk("r43_err", err_o, 0);
    chk("r43_cnt", inv_count_o, 0);
    step(1, 0, '0, '0, '0, 0, 1, 1);
    step(1, 0, '0, '0, '0, 0, 1, 0);
    chk("r43_err_late", err_o, 1);
    chk("r43_done", done_seen, 0);

    // Random traffic.
    step(0, 0, '0, '0, '0, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] h;
      bit a;
      case ($urandom_range(7))
        0: h = '0;
        1: h = '1;
        default: h = N'($urandom());
      endcase
      if (m_active && m_pend > 0) a = ($urandom_range(2) == 0);
      else a = ($urandom_range(96) == 0);
      step(($urandom_range(299) != 0), ($urandom_range(2) == 0), h, N*AW'($urandom()),
           IW'($urandom()), 1'($urandom()), ($urandom_range(3) != 0), a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
